trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Sequences synchronous exceptions, asynchronous machine interrupts and MRET into the machine-mode CSR register file.
- Collects exception requests from execute and raw interrupt lines, then prioritises them.
- Holds the front end while the pipeline drains.
- Issues one-cycle commit pulses (exception_pending, m_cause, pc_exc, m_ret) plus a PC redirect.

Parameters:
- XLEN, 32, datapath width.
- DRAIN_MAX, 15, max cycles waiting for pipe_empty before drain_err is flagged (4-bit counter).
- SYNC_STAGES, 2, flops in each interrupt synchroniser (2 or 3).

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- exc_valid  in  1  execute reports a synchronous exception this cycle
- exc_code  in  4  exception cause code (0 inst-misaligned, 2 illegal, 3 breakpoint, 4/6 ld/st misaligned, 11 ecall-M)
- exc_pc  in  XLEN  PC of the faulting instruction
- mret_req  in  1  execute retires an MRET
- irq_ext, irq_timer, irq_sw  in  1 each  raw interrupt lines, asynchronous
- m_eie, m_tie, m_sie  in  1 each  enables from CSR file, already ANDed with mstatus.MIE
- mtvec_base  in  XLEN  trap base from CSR file
- mepc_in  in  XLEN  return address from CSR file
- pipe_empty  in  1  no instruction in flight past decode
- cur_pc  in  XLEN  PC of oldest uncommitted instruction (mepc for interrupts)
- stall  out  1  hold fetch/decode
- flush  out  1  one-cycle kill of younger instructions
- exception_pending  out  1  one-cycle trap commit to CSR file
- m_cause  out  XLEN  {interrupt bit, 27'b0, code}
- pc_exc  out  XLEN  value for mepc
- m_ret  out  1  one-cycle return commit to CSR file
- asy_int  out  1  current commit is an interrupt
- redirect  out  1  one-cycle PC select
- redirect_pc  out  XLEN  new PC
- irq_pending  out  1  synchronised, enabled interrupt exists
- drain_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; synchronisers and sticky flag cleared.
- Reset mid-operation aborts any sequence; no pulse is emitted after rst deasserts until a new event arrives.
- Interrupt lines pass through irq_sync (SYNC_STAGES flops) and are then ANDed with their enables.
- Interrupt priority: EXT (11) > SW (3) > TIMER (7).
- Exception priority when several codes arrive the same cycle: not applicable, exc_code is single. exc_valid beats interrupt and beats mret_req.
- FSM states and transitions:
  - IDLE
    - exc_valid → latch code/exc_pc, asy=0, go to FLUSH.
    - Else if irq_pending → latch highest interrupt code, pc=cur_pc, asy=1, go to FLUSH.
    - Else if mret_req → go to RET.
    - flush=1 in the cycle leaving IDLE toward FLUSH or RET.
  - FLUSH
    - stall=1; the 4-bit counter increments each cycle while pipe_empty=0.
    - pipe_empty=1 → go to TRAP.
    - Counter reaches DRAIN_MAX → set drain_err (sticky until rst) and go to TRAP anyway.
  - TRAP (one cycle)
    - exception_pending=1; m_cause, pc_exc and asy_int driven from the latch.
    - redirect=1, redirect_pc=mtvec_base; stall=1.
    - Go to IDLE.
  - RET (one cycle)
    - m_ret=1, redirect=1, redirect_pc=mepc_in, stall=1.
    - Go to IDLE.
- Latency: exception with pipe_empty already 1 → exception_pending two cycles after exc_valid (IDLE→FLUSH→TRAP).
- Interrupt latency: SYNC_STAGES + 2 cycles from the raw line.
- Events arriving in FLUSH/TRAP/RET are ignored.
- The execute stage re-reports them after the redirect; the interrupt level is re-sampled in IDLE.
- m_cause[31] = asy; m_cause[3:0] = code; all other bits 0.
- pc_exc[1:0] forced to 0.

Optional Feature:
- Macro TRAP_CTRL_VECTORED_EN.
- Defined: when asy=1 in TRAP, redirect_pc = mtvec_base + (code << 2) (XLEN add, wrap ignored). Synchronous exceptions still use mtvec_base.
- Undefined: redirect_pc = mtvec_base for all traps (direct mode).

Decomposition:
- Shared package trap_pkg holds:
  - typedef trap_state_t {IDLE, FLUSH, TRAP, RET}.
  - Cause constants CAUSE_INST_MISALIGN=0, CAUSE_ILLEGAL=2, CAUSE_BREAK=3, CAUSE_LD_MISALIGN=4, CAUSE_ST_MISALIGN=6, CAUSE_ECALL_M=11, IRQ_SW=3, IRQ_TIMER=7, IRQ_EXT=11.
- One sub-module, irq_sync: a parameterised SYNC_STAGES flop chain, instantiated three times.

Test Plan:
- exc_valid=1, exc_code=2, exc_pc=0x104, pipe_empty=1, mtvec_base=0x200 → exactly one exception_pending pulse with m_cause=0x2, pc_exc=0x104, redirect_pc=0x200, asy_int=0.
- irq_timer=1, m_tie=1, cur_pc=0x80 → after SYNC_STAGES+2 cycles: m_cause=0x80000007, pc_exc=0x80, asy_int=1. With TRAP_CTRL_VECTORED_EN, redirect_pc=0x21C.
- irq_ext, irq_timer, irq_sw all asserted with all enables set → m_cause=0x8000000B. Then drop irq_ext → the next trap has m_cause=0x80000003.
- mret_req=1, mepc_in=0x104 → m_ret pulse and redirect_pc=0x104 one cycle later. With exc_valid=1 in the same cycle, the exception wins and there is no m_ret pulse.
- pipe_empty held 0 → after 15 FLUSH cycles drain_err=1 and the trap commits. drain_err stays 1 until rst.
- Assert rst during FLUSH → all outputs 0 immediately; no exception_pending after release.

Source files
------------

// File: rtl/trap_pkg.sv
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared types and cause codes for the machine-mode trap
//                controller and its interrupt synchronisers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_pkg;

    // Sequencer states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2,
        RET   = 2'd3
    } trap_state_t;

    // Synchronous exception cause codes.
    localparam logic [3:0] CAUSE_INST_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL       = 4'd2;
    localparam logic [3:0] CAUSE_BREAK         = 4'd3;
    localparam logic [3:0] CAUSE_LD_MISALIGN   = 4'd4;
    localparam logic [3:0] CAUSE_ST_MISALIGN   = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M       = 4'd11;

    // Machine interrupt cause codes.
    localparam logic [3:0] IRQ_SW    = 4'd3;
    localparam logic [3:0] IRQ_TIMER = 4'd7;
    localparam logic [3:0] IRQ_EXT   = 4'd11;

    // Highest-priority enabled interrupt: external, then software, then timer.
    function automatic logic [3:0] irq_select(input logic ext, input logic sw);
        if (ext)
            return IRQ_EXT;
        else if (sw)
            return IRQ_SW;
        else
            return IRQ_TIMER;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync.sv
// ============================================================================
//  Module      : irq_sync
//  Description : SYNC_STAGES-deep flop chain bringing one asynchronous
//                interrupt line into the clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw line through the chain; the last flop is the clean copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_chain <= '0;
        else
            r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/trap_controller.sv
// ============================================================================
//  Module      : trap_controller
//  Description : Sequences synchronous exceptions, machine interrupts and
//                MRET into the CSR file: flush, drain, commit, redirect.
//                Optional macro TRAP_CTRL_VECTORED_EN selects vectored
//                interrupt targets (mtvec_base + code*4); default is direct.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_controller
    import trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DRAIN_MAX   = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mret_req,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    input  logic            m_eie,
    input  logic            m_tie,
    input  logic            m_sie,
    input  logic [XLEN-1:0] mtvec_base,
    input  logic [XLEN-1:0] mepc_in,
    input  logic            pipe_empty,
    input  logic [XLEN-1:0] cur_pc,
    output logic            stall,
    output logic            flush,
    output logic            exception_pending,
    output logic [XLEN-1:0] m_cause,
    output logic [XLEN-1:0] pc_exc,
    output logic            m_ret,
    output logic            asy_int,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            irq_pending,
    output logic            drain_err
);

    localparam logic [3:0] c_drain_last = 4'(DRAIN_MAX - 1);

    trap_state_t     r_state, w_state_nxt;
    logic [3:0]      r_code, w_lat_code;
    logic [XLEN-1:0] r_pc, w_lat_pc;
    logic            r_asy, w_lat_asy, w_latch;
    logic [3:0]      r_cnt;
    logic            w_cnt_clr, w_cnt_inc;
    logic            r_drain_err, w_drain_set;
    logic            w_ext_s, w_tim_s, w_sw_s;
    logic            w_ext_en, w_tim_en, w_sw_en;
    logic [XLEN-1:0] w_trap_pc;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (.clk(clk), .rst(rst), .d(irq_ext),   .q(w_ext_s));
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tim (.clk(clk), .rst(rst), .d(irq_timer), .q(w_tim_s));
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw  (.clk(clk), .rst(rst), .d(irq_sw),    .q(w_sw_s));

    assign w_ext_en    = w_ext_s & m_eie;
    assign w_tim_en    = w_tim_s & m_tie;
    assign w_sw_en     = w_sw_s  & m_sie;
    assign irq_pending = w_ext_en | w_tim_en | w_sw_en;
    assign drain_err   = r_drain_err;

`ifdef TRAP_CTRL_VECTORED_EN
    // Interrupts jump to their own vector slot; exceptions share the base.
    assign w_trap_pc = r_asy ? (mtvec_base + {{(XLEN-6){1'b0}}, r_code, 2'b00}) : mtvec_base;
`else
    assign w_trap_pc = mtvec_base;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Trap latch, drain counter and sticky watchdog flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code      <= '0;
            r_pc        <= '0;
            r_asy       <= 1'b0;
            r_cnt       <= '0;
            r_drain_err <= 1'b0;
        end else begin
            if (w_latch) begin
                r_code <= w_lat_code;
                r_pc   <= w_lat_pc;
                r_asy  <= w_lat_asy;
            end
            if (w_cnt_clr)
                r_cnt <= '0;
            else if (w_cnt_inc)
                r_cnt <= r_cnt + 4'd1;
            if (w_drain_set)
                r_drain_err <= 1'b1;
        end
    end

    // Next-state selection and per-state commit outputs.
    always_comb begin
        w_state_nxt       = r_state;
        w_latch           = 1'b0;
        w_lat_code        = exc_code;
        w_lat_pc          = exc_pc;
        w_lat_asy         = 1'b0;
        w_cnt_clr         = 1'b0;
        w_cnt_inc         = 1'b0;
        w_drain_set       = 1'b0;
        stall             = 1'b0;
        flush             = 1'b0;
        exception_pending = 1'b0;
        m_cause           = '0;
        pc_exc            = '0;
        m_ret             = 1'b0;
        asy_int           = 1'b0;
        redirect          = 1'b0;
        redirect_pc       = '0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (exc_valid) begin
                    w_latch     = 1'b1;
                    flush       = 1'b1;
                    w_state_nxt = FLUSH;
                end else if (irq_pending) begin
                    w_latch     = 1'b1;
                    w_lat_code  = irq_select(w_ext_en, w_sw_en);
                    w_lat_pc    = cur_pc;
                    w_lat_asy   = 1'b1;
                    flush       = 1'b1;
                    w_state_nxt = FLUSH;
                end else if (mret_req) begin
                    flush       = 1'b1;
                    w_state_nxt = RET;
                end
            end
            FLUSH: begin
                stall = 1'b1;
                if (pipe_empty) begin
                    w_state_nxt = TRAP;
                end else if (r_cnt == c_drain_last) begin
                    // Pipe never drained: flag it and commit the trap anyway.
                    w_drain_set = 1'b1;
                    w_state_nxt = TRAP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            TRAP: begin
                stall             = 1'b1;
                exception_pending = 1'b1;
                m_cause           = {r_asy, {(XLEN-5){1'b0}}, r_code};
                pc_exc            = {r_pc[XLEN-1:2], 2'b00};
                asy_int           = r_asy;
                redirect          = 1'b1;
                redirect_pc       = w_trap_pc;
                w_state_nxt       = IDLE;
            end
            RET: begin
                stall       = 1'b1;
                m_ret       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = mepc_in;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_controller.sv
// ============================================================================
//  Module      : tb_trap_controller
//  Description : Self-checking bench for trap_controller: directed cases
//                followed by randomized traps against a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_controller;

    localparam int XLEN = 32;
    localparam int SYNC = 2;
    localparam int DMAX = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            exc_valid, mret_req;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_pc, mtvec_base, mepc_in, cur_pc;
    logic            irq_ext, irq_timer, irq_sw, m_eie, m_tie, m_sie;
    logic            pipe_empty;
    logic            stall, flush, exception_pending, m_ret, asy_int;
    logic            redirect, irq_pending, drain_err;
    logic [XLEN-1:0] m_cause, pc_exc, redirect_pc;

    int n_chk = 0;
    int n_err = 0;
    logic drain_exp = 1'b0;

    always #5 clk = ~clk;

    trap_controller #(.XLEN(XLEN), .DRAIN_MAX(DMAX), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .mret_req(mret_req),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
        .m_eie(m_eie), .m_tie(m_tie), .m_sie(m_sie),
        .mtvec_base(mtvec_base), .mepc_in(mepc_in),
        .pipe_empty(pipe_empty), .cur_pc(cur_pc),
        .stall(stall), .flush(flush), .exception_pending(exception_pending),
        .m_cause(m_cause), .pc_exc(pc_exc), .m_ret(m_ret), .asy_int(asy_int),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .irq_pending(irq_pending), .drain_err(drain_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One trap transaction. lines/en are {ext, sw, timer}. k is the number of
    // FLUSH cycles that see pipe_empty=0 before it rises.
    task automatic run_trap(input bit is_irq, input logic [3:0] code, input logic [31:0] pc,
                            input logic [2:0] lines, input logic [2:0] en, input int k,
                            input bit distract, input bit with_mret);
        logic [2:0]  eff;
        logic [3:0]  icode;
        logic [31:0] exp_cause, exp_rpc;
        int          flush_start, exp_lat, lat;
        bit          seen;
        // Reference: cause from priority rules, latency from drain length.
        if (is_irq) begin
            eff         = lines & en;
            icode       = eff[2] ? 4'd11 : (eff[1] ? 4'd3 : 4'd7);
            exp_cause   = 32'h8000_0000 | 32'(icode);
`ifdef TRAP_CTRL_VECTORED_EN
            exp_rpc     = mtvec_base + 32'(icode) * 4;
`else
            exp_rpc     = mtvec_base;
`endif
            flush_start = SYNC + 1;
        end else begin
            exp_cause   = 32'(code);
            exp_rpc     = mtvec_base;
            flush_start = 1;
        end
        exp_lat = flush_start + ((k < DMAX) ? k + 1 : DMAX);
        if (k >= DMAX) drain_exp = 1'b1;

        if (is_irq) begin
            {irq_ext, irq_sw, irq_timer} = lines;
            {m_eie, m_sie, m_tie}        = en;
            cur_pc = pc;
        end else begin
            exc_valid = 1'b1;
            exc_code  = code;
            exc_pc    = pc;
            mret_req  = with_mret;
            mepc_in   = $urandom;
        end
        pipe_empty = 1'($urandom);
        if (!is_irq) begin
            #1;
            check("flush_exc", 32'(flush), 32'd1);
        end

        seen = 1'b0;
        lat  = 0;
        for (int t = 1; t <= 60 && !seen; t++) begin
            tick();
            if (is_irq && t == SYNC) begin
                check("irq_pending", 32'(irq_pending), 32'd1);
                check("flush_irq", 32'(flush), 32'd1);
            end
            if (exception_pending) begin
                seen = 1'b1;
                lat  = t;
                exc_valid = 1'b0;
                mret_req  = 1'b0;
                if (is_irq) begin
                    {irq_ext, irq_sw, irq_timer} = 3'b000;
                    {m_eie, m_sie, m_tie}        = 3'b000;
                end
            end else begin
                check("no_mret", 32'(m_ret), 32'd0);
                if (t == 1 && !is_irq) begin
                    exc_valid = 1'b0;
                    mret_req  = 1'b0;
                end
                if (t >= flush_start) begin
                    check("stall_flush", 32'(stall), 32'd1);
                    pipe_empty = (t - flush_start >= k);
                    if (distract) begin
                        exc_valid = 1'($urandom);
                        mret_req  = 1'($urandom);
                        exc_code  = 4'($urandom);
                    end
                end
            end
        end

        if (!seen) begin
            check("trap_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(exp_lat));
            check("m_cause", m_cause, exp_cause);
            check("pc_exc", pc_exc, pc & ~32'h3);
            check("asy_int", 32'(asy_int), 32'(is_irq));
            check("redirect", 32'(redirect), 32'd1);
            check("redirect_pc", redirect_pc, exp_rpc);
            check("stall_trap", 32'(stall), 32'd1);
            check("m_ret_trap", 32'(m_ret), 32'd0);
            check("drain_err", 32'(drain_err), 32'(drain_exp));
        end
        pipe_empty = 1'b1;
        tick();
        check("single_pulse", 32'(exception_pending), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
        check("drain_sticky", 32'(drain_err), 32'(drain_exp));
        if (is_irq) repeat (SYNC) tick();
    endtask

    task automatic run_mret(input logic [31:0] epc);
        mepc_in    = epc;
        mret_req   = 1'b1;
        pipe_empty = 1'($urandom);
        #1;
        check("flush_mret", 32'(flush), 32'd1);
        tick();
        mret_req = 1'b0;
        check("m_ret", 32'(m_ret), 32'd1);
        check("ret_redirect", 32'(redirect), 32'd1);
        check("ret_pc", redirect_pc, epc);
        check("ret_stall", 32'(stall), 32'd1);
        check("ret_no_exc", 32'(exception_pending), 32'd0);
        tick();
        check("m_ret_done", 32'(m_ret), 32'd0);
        check("redirect_done", 32'(redirect), 32'd0);
    endtask

    task automatic run_reset_abort();
        exc_valid  = 1'b1;
        exc_code   = 4'd3;
        exc_pc     = 32'h0000_0300;
        pipe_empty = 1'b0;
        tick();
        exc_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        drain_exp = 1'b0;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_exc", 32'(exception_pending), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_cause", m_cause, 32'd0);
        check("rst_drain", 32'(drain_err), 32'd0);
        tick();
        rst = 1'b0;
        pipe_empty = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_exc", 32'(exception_pending), 32'd0);
            check("post_rst_stall", 32'(stall), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  codes [6];
        logic [2:0]  ln, en;
        int          sel, k;
        codes = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'd11};
        rst = 1'b1;
        exc_valid = 1'b0; mret_req = 1'b0; exc_code = '0; exc_pc = '0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
        m_eie = 1'b0; m_tie = 1'b0; m_sie = 1'b0;
        mtvec_base = 32'h0000_0200; mepc_in = '0; cur_pc = '0; pipe_empty = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_exc", 32'(exception_pending), 32'd0);
        check("reset_redirect", 32'(redirect), 32'd0);
        check("reset_irq_pending", 32'(irq_pending), 32'd0);
        check("reset_drain", 32'(drain_err), 32'd0);
        rst = 1'b0;
        tick();

        run_trap(1'b0, 4'd2, 32'h0000_0104, 3'b000, 3'b000, 0, 1'b0, 1'b0);
        run_trap(1'b1, 4'd0, 32'h0000_0080, 3'b001, 3'b001, 0, 1'b0, 1'b0);
        run_trap(1'b1, 4'd0, 32'h0000_0090, 3'b111, 3'b111, 0, 1'b0, 1'b0);
        run_trap(1'b1, 4'd0, 32'h0000_0094, 3'b011, 3'b111, 0, 1'b0, 1'b0);
        run_mret(32'h0000_0104);
        run_trap(1'b0, 4'd11, 32'h0000_0400, 3'b000, 3'b000, 0, 1'b0, 1'b1);
        run_trap(1'b0, 4'd4, 32'h0000_0502, 3'b000, 3'b000, 14, 1'b0, 1'b0);
        check("no_drain_at_14", 32'(drain_err), 32'd0);
        run_trap(1'b0, 4'd6, 32'h0000_0600, 3'b000, 3'b000, 15, 1'b0, 1'b0);
        run_trap(1'b0, 4'd0, 32'h0000_0700, 3'b000, 3'b000, 0, 1'b0, 1'b0);
        run_reset_abort();

        for (int n = 0; n < 40; n++) begin
            mtvec_base = $urandom;
            k   = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 3);
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                run_trap(1'b0, codes[$urandom_range(0, 5)], $urandom, 3'b000, 3'b000, k,
                         1'($urandom), 1'($urandom));
            end else if (sel == 1) begin
                do begin
                    ln = 3'($urandom);
                    en = 3'($urandom);
                end while ((ln & en) == 3'b000);
                run_trap(1'b1, 4'd0, $urandom, ln, en, k, 1'($urandom), 1'b0);
            end else begin
                run_mret($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
